// File: rtl/ram_dumper_pkg.sv
// Shared constants for the RAM upload path: FSM state encodings, default
// frame header and the fixed per-frame overhead (header, two length bytes, checksum).
package ram_dumper_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR,
      ST_LENH,
      ST_LENL,
      ST_WAIT,
      ST_RD,
      ST_RDLAT,
      ST_CSUM,
      ST_FIN
   } state_t;

   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
   localparam int         FRAME_OVERHEAD   = 4;

   // Total bytes on the wire for a dump of len data bytes.
   function automatic logic [16:0] frame_bytes(input logic [15:0] len);
      return {1'b0, len} + 17'(FRAME_OVERHEAD);
   endfunction

endpackage

// File: rtl/ram_dumper_if.sv
// RAM read port plus UART TX handshake as seen by the dumper. The dumper is
// the master; the RAM/UART side (or the mux in front of them) is the slave.
interface ram_dumper_if #(
   parameter int ADDR_BITS = 16
);

   logic [ADDR_BITS-1:0] ram_addr;
   logic [7:0]           ram_data;
   logic [7:0]           tx_data;
   logic                 transmit;
   logic                 tx_done;

   modport master (
      output ram_addr,
      output tx_data,
      output transmit,
      input  ram_data,
      input  tx_done
   );

   modport slave (
      input  ram_addr,
      input  tx_data,
      input  transmit,
      output ram_data,
      output tx_done
   );

endinterface

// File: rtl/ram_dumper_edge_detect.sv
// Registered rising-edge detector. The input is registered once, so an edge
// is reported one cycle after it appears at the input. Shared with the bootloader.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;
   logic sig_qq;

   // Two-stage history of the input; rise compares the newest two samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_q  <= 1'b0;
         sig_qq <= 1'b0;
      end else begin
         sig_q  <= sig;
         sig_qq <= sig_q;
      end
   end

   assign rise = sig_q & ~sig_qq;

endmodule

// File: rtl/ram_dumper.sv
// Streams a RAM region out of the UART as a framed dump:
// header, length (MSB first), data bytes, 8-bit additive checksum of the data.
// While a frame is in flight the CPU is held in reset and this block owns
// the RAM read port and the UART TX handshake (selected by dumping).
module ram_dumper
   import ram_dumper_pkg::*;
#(
   parameter int         ADDR_BITS = 16,
   parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 trigger,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [15:0]          length,
   ram_dumper_if.master         bus,
   output logic                 dumping,
   output logic                 cpu_rst,
   output logic                 done
);

   state_t               state;
   state_t               ret_state;
   logic [ADDR_BITS-1:0] ptr;
   logic [15:0]          remaining;
   logic [7:0]           csum;
   logic                 trig_rise;

   edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (trigger),
      .rise (trig_rise)
   );

   // Frame sequencer. Every output is registered; transmit and done are
   // single-cycle pulses. ST_WAIT parks on the UART until tx_done and then
   // follows ret_state; ret_state == ST_RD means "next data byte or checksum".
   // The RAM address is launched on the way out of ST_WAIT and held through
   // ST_RD, so a synchronous RAM presents the byte during ST_RDLAT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         ret_state    <= ST_IDLE;
         ptr          <= '0;
         remaining    <= '0;
         csum         <= '0;
         bus.ram_addr <= '0;
         bus.tx_data  <= '0;
         bus.transmit <= 1'b0;
         dumping      <= 1'b0;
         cpu_rst      <= 1'b0;
         done         <= 1'b0;
      end else begin
         bus.transmit <= 1'b0;
         done         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig_rise) begin
                  ptr       <= start_addr;
                  remaining <= length;
                  csum      <= '0;
                  dumping   <= 1'b1;
                  cpu_rst   <= 1'b1;
                  state     <= ST_HDR;
               end
            end
            ST_HDR: begin
               bus.tx_data  <= HDR_BYTE;
               bus.transmit <= 1'b1;
               ret_state    <= ST_LENH;
               state        <= ST_WAIT;
            end
            ST_LENH: begin
               bus.tx_data  <= remaining[15:8];
               bus.transmit <= 1'b1;
               ret_state    <= ST_LENL;
               state        <= ST_WAIT;
            end
            ST_LENL: begin
               bus.tx_data  <= remaining[7:0];
               bus.transmit <= 1'b1;
               ret_state    <= ST_RD;
               state        <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.tx_done) begin
                  if (ret_state == ST_RD) begin
                     if (remaining != 16'd0) begin
                        bus.ram_addr <= ptr;
                        state        <= ST_RD;
                     end else begin
                        state <= ST_CSUM;
                     end
                  end else begin
                     state <= ret_state;
                  end
               end
            end
            ST_RD: begin
               state <= ST_RDLAT;
            end
            ST_RDLAT: begin
               bus.tx_data  <= bus.ram_data;
               bus.transmit <= 1'b1;
               csum         <= csum + bus.ram_data;
               ptr          <= ptr + ADDR_BITS'(1);
               remaining    <= remaining - 16'd1;
               ret_state    <= ST_RD;
               state        <= ST_WAIT;
            end
            ST_CSUM: begin
               bus.tx_data  <= csum;
               bus.transmit <= 1'b1;
               ret_state    <= ST_FIN;
               state        <= ST_WAIT;
            end
            ST_FIN: begin
               done    <= 1'b1;
               dumping <= 1'b0;
               cpu_rst <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_dumper.md
# ram_dumper

Reads a contiguous RAM region and streams it to the host over the UART transmitter: the upload path that complements the UART bootloader's download path. On a trigger it holds the CPU in reset, takes ownership of the RAM address/read port and the UART TX handshake, and sends a framed dump: header, length, data, checksum. It releases everything when the frame completes. It sits beside the bootloader, muxed onto the RAM and UART by its `dumping` flag.

## Interface
- `ADDR_BITS`, 16: RAM address width; addresses wrap modulo 2^ADDR_BITS.
- `HDR_BYTE`, 8'hA5: frame header byte.
- `clk`  in  1  system clock; RAM and UART run on the same clock.
- `rst`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  level input, rising-edge detected internally; starts a dump.
- `start_addr`  in  ADDR_BITS  first address; sampled on the trigger edge.
- `length`  in  16  byte count; sampled on the trigger edge; 0 gives an empty frame.
- `ram_addr`  out  ADDR_BITS  RAM read address.
- `ram_data`  in  8  RAM read data; valid one cycle after `ram_addr` is presented.
- `tx_data`  out  8  byte to transmit.
- `transmit`  out  1  one-cycle pulse; the UART loads `tx_data`.
- `tx_done`  in  1  one-cycle pulse from the UART when a byte has finished shifting out.
- `dumping`  out  1  high while a frame is in progress; selects this block on the RAM/UART muxes.
- `cpu_rst`  out  1  holds the CPU in reset while dumping.
- `done`  out  1  one-cycle pulse when the frame completes.

## Operation
- Frame on the wire: `HDR_BYTE`, `length[15:8]`, `length[7:0]`, `length` data bytes from `start_addr` upward, then the checksum.
- Checksum: 8-bit sum, mod 256, of the data bytes only. It is 8'h00 for an empty frame.
- States:
  - IDLE: on the trigger rising edge, latch `start_addr` and `length`, clear the checksum, go to HDR.
  - HDR, LENH, LENL: load the byte, pulse `transmit`, go to WAIT with the return state recorded.
  - WAIT: hold until `tx_done`, then go to the return state.
    - After LENL, or after each data byte: go to RD if remaining > 0, else CSUM.
  - RD: drive `ram_addr` = current pointer, go to RDLAT.
  - RDLAT: capture `ram_data` into `tx_data`, add it to the checksum, increment the pointer (wrapping), decrement remaining, pulse `transmit`, go to WAIT.
  - CSUM: send the checksum byte, go to WAIT, then FIN.
  - FIN: pulse `done`, deassert `dumping` and `cpu_rst`, go to IDLE.
- Retrigger: edges while not IDLE are ignored. An edge is not remembered.
- Stray `tx_done` outside WAIT is ignored.
- `transmit` is never asserted while a byte is still awaiting its `tx_done`.

## Timing
- Reset values, applied asynchronously:
  - state IDLE;
  - `transmit`, `done`, `dumping`, `cpu_rst` all 0;
  - `tx_data`, `ram_addr`, checksum, pointer, remaining all 0;
  - edge-detect register 0.
- Reset mid-frame: the frame aborts immediately and nothing further is sent. The host detects the truncated frame.
- Trigger-edge latency: the trigger is registered; the edge is seen one cycle after it appears at the input.
  - `dumping` and `cpu_rst` go high the cycle after the edge is seen.
  - The first `transmit` follows one cycle after that.
- `tx_done` to the next `transmit`:
  - 1 cycle for header, length and checksum bytes;
  - 2 cycles for data bytes (RD, then RDLAT).
- `done` pulses one cycle after the checksum's `tx_done`. `dumping` falls on that same cycle.
- `tx_done` and the trigger edge arriving in the same cycle: handled independently (trigger is ignored when not IDLE).

## Structure
- Shared constants header: state encodings, `HDR_BYTE` default, and the frame-length overhead of 4 bytes.
- One natural sub-module: `edge_detect`, a registered rising-edge detector for `trigger`, reusable by the bootloader.
- The rest is a single FSM with a byte counter, an address pointer and a checksum accumulator.

## Test plan
- RAM[0x0010..0x0013] = 01 02 03 04, start = 0x0010, len = 4 → bytes A5 00 04 01 02 03 04 0A, then one `done` pulse.
- len = 0 → A5 00 00 00; RAM is never read.
- Wrap: start = 0xFFFE, len = 3, RAM[FFFE] = 10, RAM[FFFF] = 20, RAM[0000] = 30 → data 10 20 30, checksum 60.
- Overflowing checksum: len = 2, data FF FF → checksum FE.
- Second trigger edge during the frame → ignored, and exactly one frame is sent. Stray `tx_done` pulses while IDLE → no `transmit`.
- Reset asserted after the 3rd data byte's `transmit` → all outputs return to reset values asynchronously. A new trigger then produces a complete frame.
